// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring
// divider sharing one four-state sequencer with a fixed 34-cycle turnaround.
module muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [4:0]            alu_op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic                  flush_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o
);

   localparam int W = DATA_WIDTH;

   typedef enum logic [4:0] {
      OP_MULU   = 5'b01001,
      OP_MULHS  = 5'b01010,
      OP_MULHSU = 5'b01011,
      OP_MULHU  = 5'b01100,
      OP_DIVU   = 5'b01101,
      OP_DIVS   = 5'b01110,
      OP_REMU   = 5'b01111,
      OP_REMS   = 5'b10000
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_e;

   state_e         state_q;
   logic [4:0]     op_q;
   logic [5:0]     cnt_q;
   logic [2*W-1:0] prod_q;
   logic [W-1:0]   opa_q;
   logic [W-1:0]   opb_q;
   logic [W-1:0]   rem_q;
   logic [W-1:0]   quot_q;
   logic           neg_res_q;
   logic           neg_rem_q;
   logic           div0_q;
   logic           busy_q;
   logic           done_q;
   logic [W-1:0]   result_q;

   logic           op_valid;
   logic           op_is_mul;
   logic           a_signed;
   logic           b_signed;
   logic           a_neg;
   logic           b_neg;
   logic [W-1:0]   a_mag;
   logic [W-1:0]   b_mag;
   logic [W:0]     mul_sum;
   logic [W:0]     div_shift;
   logic           div_ge;
   logic [W-1:0]   div_rem_sub;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quot_fix;
   logic [W-1:0]   rem_fix;
   logic [W-1:0]   fix_result;

   // Decode the incoming opcode: validity and which operands are signed.
   always_comb begin
      op_valid = 1'b1;
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (alu_op_i)
         OP_MULU,
         OP_MULHU,
         OP_DIVU,
         OP_REMU:   ;
         OP_MULHS,
         OP_DIVS,
         OP_REMS:   begin a_signed = 1'b1; b_signed = 1'b1; end
         OP_MULHSU: a_signed = 1'b1;
         default:   op_valid = 1'b0;
      endcase
      a_neg = a_signed & a_i[W-1];
      b_neg = b_signed & b_i[W-1];
      a_mag = a_neg ? -a_i : a_i;
      b_mag = b_neg ? -b_i : b_i;
   end

   // One iteration of each datapath plus the sign-corrected result select.
   always_comb begin
      op_is_mul   = (op_q == OP_MULU) || (op_q == OP_MULHS) ||
                    (op_q == OP_MULHSU) || (op_q == OP_MULHU);
      // Right-shifting product: upper half accumulates, low half collects finished bits.
      mul_sum     = {1'b0, prod_q[2*W-1:W]} + (opb_q[0] ? {1'b0, opa_q} : '0);
      div_shift   = {rem_q, quot_q[W-1]};
      div_ge      = div_shift >= {1'b0, opb_q};
      div_rem_sub = div_shift[W-1:0] - opb_q;
      prod_fix    = neg_res_q ? -prod_q : prod_q;
      // A zero divisor yields all-ones regardless of the dividend sign.
      quot_fix    = div0_q ? '1 : (neg_res_q ? -quot_q : quot_q);
      rem_fix     = neg_rem_q ? -rem_q : rem_q;
      case (op_q)
         OP_MULU:                     fix_result = prod_fix[W-1:0];
         OP_MULHS, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*W-1:W];
         OP_DIVU, OP_DIVS:            fix_result = quot_fix;
         default:                     fix_result = rem_fix;
      endcase
   end

   // Sequencer and datapath registers: IDLE -> CALC (W cycles) -> FIX -> DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         op_q      <= '0;
         cnt_q     <= '0;
         prod_q    <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         rem_q     <= '0;
         quot_q    <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else if (flush_i) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start_i && op_valid) begin
                  state_q   <= CALC;
                  busy_q    <= 1'b1;
                  op_q      <= alu_op_i;
                  cnt_q     <= '0;
                  prod_q    <= '0;
                  rem_q     <= '0;
                  opa_q     <= a_mag;
                  opb_q     <= b_mag;
                  quot_q    <= a_mag;
                  neg_res_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  div0_q    <= (b_i == '0);
               end
            end
            CALC: begin
               if (op_is_mul) begin
                  prod_q <= {mul_sum, prod_q[W-1:1]};
                  opb_q  <= opb_q >> 1;
               end else if (div_ge) begin
                  rem_q  <= div_rem_sub;
                  quot_q <= {quot_q[W-2:0], 1'b1};
               end else begin
                  rem_q  <= div_shift[W-1:0];
                  quot_q <= {quot_q[W-2:0], 1'b0};
               end
               if (cnt_q == 6'(W-1)) begin
                  state_q <= FIX;
               end else begin
                  cnt_q <= cnt_q + 6'd1;
               end
            end
            FIX: begin
               result_q <= fix_result;
               done_q   <= 1'b1;
               state_q  <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus start/flush/reset sequences.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  alu_op = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   localparam logic [4:0] MULU = 5'b01001, MULHS = 5'b01010, MULHSU = 5'b01011,
                          MULHU = 5'b01100, DIVU = 5'b01101, DIVS = 5'b01110,
                          REMU = 5'b01111, REMS = 5'b10000, ADD = 5'b00010;

   muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start),
      .alu_op_i (alu_op),
      .a_i      (a),
      .b_i      (b),
      .flush_i  (flush),
      .busy_o   (busy),
      .done_o   (done),
      .result_o (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one op, scramble operands after the start edge, and time the done strobe.
   task automatic run_op(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb,
                         output int lat, output logic busy1, output logic done_after,
                         output logic [31:0] res);
      @(negedge clk);
      alu_op = op; a = va; b = vb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = ~va; b = ~vb; alu_op = ADD;
      lat = -1; busy1 = 1'b0; res = result;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (k == 1) busy1 = busy;
         if (done) begin lat = k; res = result; end
      end
      @(posedge clk); #1;
      done_after = done;
   endtask

   initial begin
      int          lat;
      logic        busy1, done_after, seen_done, seen_busy;
      logic [31:0] res;

      vecs.push_back('{MULU,   32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB});
      vecs.push_back('{MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE});
      vecs.push_back('{MULHS,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000});
      vecs.push_back('{MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF});
      vecs.push_back('{MULHS,  32'h80000000,   32'h80000000, 32'h40000000});
      vecs.push_back('{MULHSU, 32'h80000000,   32'd2,        32'hFFFFFFFF});
      vecs.push_back('{DIVS,   32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD});
      vecs.push_back('{REMS,   32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF});
      vecs.push_back('{DIVU,   32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC});
      vecs.push_back('{REMU,   32'hFFFFFFF9,   32'd2,        32'h00000001});
      vecs.push_back('{DIVS,   32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD});
      vecs.push_back('{REMS,   32'd7,          32'hFFFFFFFE, 32'h00000001});
      vecs.push_back('{DIVU,   32'd100,        32'd7,        32'd14});
      vecs.push_back('{REMU,   32'd100,        32'd7,        32'd2});
      vecs.push_back('{DIVU,   32'd5,          32'd0,        32'hFFFFFFFF});
      vecs.push_back('{REMU,   32'd5,          32'd0,        32'd5});
      vecs.push_back('{DIVS,   32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF});
      vecs.push_back('{REMS,   32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9});
      vecs.push_back('{DIVS,   32'h80000000,   32'hFFFFFFFF, 32'h80000000});
      vecs.push_back('{REMS,   32'h80000000,   32'hFFFFFFFF, 32'h00000000});

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy1, done_after, res);
         check($sformatf("vec%0d result", i), res, vecs[i].exp);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'd33);
         check($sformatf("vec%0d busy_edge1", i), {31'd0, busy1}, 32'd1);
         check($sformatf("vec%0d done_one_cycle", i), {31'd0, done_after}, 32'd0);
      end

      // Invalid opcode is ignored
      @(negedge clk);
      alu_op = ADD; a = 32'd1; b = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen_busy = 1'b0; seen_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (busy) seen_busy = 1'b1;
         if (done) seen_done = 1'b1;
      end
      check("invalid op busy", {31'd0, seen_busy}, 32'd0);
      check("invalid op done", {31'd0, seen_done}, 32'd0);

      // Start during CALC is ignored
      @(negedge clk);
      alu_op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1; res = result;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (k == 5) begin start = 1'b1; alu_op = MULU; a = 32'd3; b = 32'd3; end
         else start = 1'b0;
         if (done) begin lat = k; res = result; end
      end
      check("ignored start result", res, 32'd14);
      check("ignored start latency", 32'(lat), 32'd33);
      @(posedge clk); #1;
      check("ignored start idle after done", {31'd0, busy}, 32'd0);

      // Flush mid-operation
      @(negedge clk);
      alu_op = DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen_done = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 9) flush = 1'b1;
         if (k == 10) begin
            flush = 1'b0;
            check("flush busy", {31'd0, busy}, 32'd0);
         end
         if (done) seen_done = 1'b1;
      end
      check("flush no done", {31'd0, seen_done}, 32'd0);
      check("flush result kept", result, 32'd14);

      // Reset mid-operation
      @(negedge clk);
      alu_op = MULU; a = 32'd5; b = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen_done = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 19) rst = 1'b1;
         if (k == 20) begin
            rst = 1'b0;
            check("midop rst busy", {31'd0, busy}, 32'd0);
            check("midop rst done", {31'd0, done}, 32'd0);
            check("midop rst result", result, 32'd0);
         end
         if (done) seen_done = 1'b1;
      end
      check("midop rst no done", {31'd0, seen_done}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width; only 32 is supported for RV32IM.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start_i, input, 1 bit: request to begin an operation, sampled only in IDLE.
REQ-005 SHALL have port alu_op_i, input, 5 bits: operation code from the ALU decoder.
REQ-006 SHALL have port a_i, input, DATA_WIDTH bits: rs1 operand (multiplicand or dividend).
REQ-007 SHALL have port b_i, input, DATA_WIDTH bits: rs2 operand (multiplier or divisor).
REQ-008 SHALL have port flush_i, input, 1 bit: abort any in-flight operation.
REQ-009 SHALL have port busy_o, output, 1 bit: high in every state other than IDLE.
REQ-010 SHALL have port done_o, output, 1 bit: single-cycle result-valid strobe.
REQ-011 SHALL have port result_o, output, DATA_WIDTH bits: registered result.

Function
REQ-012 SHALL accept these 8 codes: 01001 mulu (low 32 bits), 01010 mulhs (high, signed x signed), 01011 mulhsu (high, signed a x unsigned b), 01100 mulhu (high, unsigned), 01101 divu, 01110 divs, 01111 remu, 10000 rems.
REQ-013 SHALL ignore start_i when alu_op_i is any other code: no state change and no done_o.
REQ-014 SHALL use exactly four states: IDLE, CALC, FIX, DONE.
REQ-015 IDLE -> CALC on start_i=1 with a valid code; at that edge, latch the op, latch the operand magnitudes (absolute values for signed operands), record the result-sign flags, and clear iteration counter and accumulator.
REQ-016 CALC SHALL run one iteration per cycle for exactly DATA_WIDTH cycles: shift-add for multiply, restoring shift-subtract for divide; 64-bit product, 32-bit quotient and 32-bit remainder registers.
REQ-017 CALC -> FIX when the counter reaches DATA_WIDTH-1; the counter is 6 bits and never wraps.
REQ-018 FIX SHALL apply sign correction, select the low half, high half, quotient or remainder, write result_o, and go to DONE.
REQ-019 DONE SHALL hold done_o=1 for exactly one cycle, then go to IDLE; done_o SHALL be 0 in all other states.
REQ-020 Latency is fixed for every op: if start is sampled at edge E0, done_o=1 between edges E0+DATA_WIDTH+1 and E0+DATA_WIDTH+2 (edges 33 and 34 for DATA_WIDTH=32).
REQ-021 A new start_i SHALL be accepted at the edge that leaves DONE only if the unit is already in IDLE; start_i is ignored in CALC, FIX and DONE.
REQ-022 result_o SHALL hold its value until the next FIX write; a_i, b_i and alu_op_i may change freely after the start edge.
REQ-023 Divide by zero: quotient = all ones and remainder = a_i, for both signed and unsigned, with unchanged latency.
REQ-024 Signed overflow (0x80000000 / 0xFFFFFFFF): divs quotient = 0x80000000 and rems remainder = 0, with unchanged latency.
REQ-025 Signed division truncates toward zero; the remainder takes the sign of the dividend.
REQ-026 flush_i=1 in any state SHALL force IDLE at the next edge with no done_o and result_o unchanged; flush_i takes priority over start_i.

Reset
REQ-027 With rst=1 at an edge, the unit SHALL enter IDLE and drive busy_o=0, done_o=0 and result_o=0; the counter and all datapath registers are cleared.
REQ-028 rst SHALL take priority over flush_i and start_i, and rst mid-operation SHALL discard the operation without a done_o.

Verification
REQ-029 mulu, a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; done_o high exactly 33 edges after the start edge; busy_o high from edge 1 through edge 33.
REQ-030 a=b=0xFFFFFFFF: mulhu -> 0xFFFFFFFE, mulhs -> 0x00000000, mulhsu -> 0xFFFFFFFF.
REQ-031 a=0xFFFFFFF9 (-7), b=2: divs -> 0xFFFFFFFD, rems -> 0xFFFFFFFF, divu -> 0x7FFFFFFC, remu -> 1.
REQ-032 divu/remu with a=5, b=0 -> 0xFFFFFFFF / 5; divs/rems with a=0x80000000, b=0xFFFFFFFF -> 0x80000000 / 0; latency 33 in every case.
REQ-033 Start divu, assert start_i with new operands at cycle 5 -> ignored and the first result is correct; flush_i at cycle 10 -> busy_o=0 next cycle, no done_o, result_o unchanged; rst at cycle 20 of another op -> all outputs 0.
REQ-034 start_i with alu_op_i=00010 (add) -> busy_o stays 0 and done_o never asserts.
